// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit.
// Optional feature macro: MAU_ROTATE_UNALIGNED_EN (word accesses with
// addr[1:0] != 0 are issued aligned, loads rotated, instead of faulting).
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mau_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int mau_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Size 2'b10 falls into the word branch.
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    if (size == SIZE_BYTE) begin
      mis = 1'b0;
    end else if (size == SIZE_HALF) begin
      mis = a[0];
    end else begin
`ifdef MAU_ROTATE_UNALIGNED_EN
      mis = 1'b0;
`else
      mis = (a != 2'b00);
`endif
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request / memory / response signal bundle of the memory access unit.
// Optional feature macro: MAU_ROTATE_UNALIGNED_EN (no effect on this file).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        resp_valid;
  logic        align_fault;
  logic        bus_fault;
  logic [31:0] data_from_mem;

  // The unit itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, mem_rdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, align_fault, bus_fault, data_from_mem
  );

  // CPU side plus memory model driving the unit.
  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, mem_rdata, mem_ack,
    input  req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           resp_valid, align_fault, bus_fault, data_from_mem
  );
endinterface

// File: rtl/mau_lane_steer.sv
// Little-endian byte-lane steering: store byte enables and replication,
// load extraction with zero fill.
// Optional feature macro: MAU_ROTATE_UNALIGNED_EN (word loads rotated right
// by 8*addr[1:0]).
module mau_lane_steer
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic is_byte;
  logic is_half;
  logic [7:0] sel_byte;

  assign is_byte = (size_i == SIZE_BYTE);
  assign is_half = (size_i == SIZE_HALF);

  // Store lanes; loads always read the full word.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (we_i) begin
      if (is_byte) begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end else if (is_half) begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
    end
  end

  // Right-justify the addressed lanes of the read word.
  always_comb begin
    case (addr_lo_i)
      2'd0:    sel_byte = rdata_i[7:0];
      2'd1:    sel_byte = rdata_i[15:8];
      2'd2:    sel_byte = rdata_i[23:16];
      default: sel_byte = rdata_i[31:24];
    endcase
    if (is_byte) begin
      rdata_o = {24'h0, sel_byte};
    end else if (is_half) begin
      rdata_o = {16'h0, addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0]};
    end else begin
`ifdef MAU_ROTATE_UNALIGNED_EN
      case (addr_lo_i)
        2'd0:    rdata_o = rdata_i;
        2'd1:    rdata_o = {rdata_i[7:0],  rdata_i[31:8]};
        2'd2:    rdata_o = {rdata_i[15:0], rdata_i[31:16]};
        default: rdata_o = {rdata_i[23:0], rdata_i[31:24]};
      endcase
`else
      rdata_o = rdata_i;
`endif
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access unit: accepts a CPU request, runs the
// handshake with a variable-latency memory (with timeout), and returns a
// one-cycle response pulse with fault flags and extracted load data.
// Optional feature macro: MAU_ROTATE_UNALIGNED_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  mem_access_unit_if.slave bus
);

  localparam int CNT_W = mau_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             align_q, align_d;
  logic             busf_q, busf_d;
  logic [31:0]      dfm_q, dfm_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;

  logic        accept;
  logic        in_access;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign in_access = (state_q == ACCESS);

  mau_lane_steer u_steer (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .we_i      (we_q),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.mem_rdata),
    .be_o      (be),
    .wdata_o   (wdata_rep),
    .rdata_o   (ld_data)
  );

  // Request fields captured on accept; held for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      we_q    <= bus.req_we;
    end
  end

  // Control state, timeout counter, fault flags and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      align_q <= 1'b0;
      busf_q  <= 1'b0;
      dfm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
      busf_q  <= busf_d;
      dfm_q   <= dfm_d;
    end
  end

  // Next-state logic; mem_ack only matters while in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    align_d = align_q;
    busf_d  = busf_q;
    dfm_d   = dfm_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = '0;
          if (mau_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d = RESP;
            align_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_ack) begin
          state_d = RESP;
          if (!we_q) dfm_d = ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          busf_d  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        align_d = 1'b0;
        busf_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero outside ACCESS.
  assign bus.req_ready     = (state_q == IDLE);
  assign bus.mem_en        = in_access;
  assign bus.mem_we        = in_access & we_q;
  assign bus.mem_addr      = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be        = in_access ? be : 4'h0;
  assign bus.mem_wdata     = in_access ? wdata_rep : 32'h0;
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.align_fault   = align_q;
  assign bus.bus_fault     = busf_q;
  assign bus.data_from_mem = dfm_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against a lane-arithmetic reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic clk;
  logic rst;
  int   nvec;
  int   nfail;
  logic [31:0] model_dfm;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] s, input logic [31:0] addr);
    int n;
    n = nbytes(s);
`ifdef MAU_ROTATE_UNALIGNED_EN
    if (n == 4) return 1'b0;
`endif
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [1:0] s, input logic [31:0] addr);
    int n;
    int start;
    if (!we) return 4'hF;
    n = nbytes(s);
    start = (n == 4) ? 0 : (int'(addr[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << start);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic [31:0] addr, input logic [31:0] rd);
    int n;
    int a;
    logic [31:0] mask;
    n = nbytes(s);
    a = int'(addr[1:0]);
    if (n == 4) begin
`ifdef MAU_ROTATE_UNALIGNED_EN
      if (a != 0) return (rd >> (8*a)) | (rd << (32 - 8*a));
`endif
      return rd;
    end
    mask = (32'h1 << (8*n)) - 32'h1;
    return (rd >> (8*a)) & mask;
  endfunction

  // One complete transaction. ack_after = number of mem_en cycles before the
  // ack cycle; ack_after >= TO means the memory never answers.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] s, input logic [31:0] wd,
                      input logic [31:0] rd, input int ack_after);
    int cyc;
    int en_cyc;
    logic mis;
    logic acked;
    logic [31:0] exp_d;
    mis   = m_mis(s, addr);
    acked = !mis && (ack_after < TO);
    exp_d = (!we && acked) ? m_load(s, addr, rd) : model_dfm;

    @(negedge clk);
    chk({tag, ".ready_before"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = s;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    cyc    = 0;
    en_cyc = 0;
    while (!bus.resp_valid && cyc < 40) begin
      if (bus.mem_en) begin
        chk({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".mem_be"}, {28'b0, bus.mem_be}, {28'b0, m_be(we, s, addr)});
        chk({tag, ".mem_we"}, {31'b0, bus.mem_we}, {31'b0, we});
        chk({tag, ".ready_busy"}, {31'b0, bus.req_ready}, 32'd0);
        if (we) chk({tag, ".mem_wdata"}, bus.mem_wdata, m_wdata(s, wd));
        bus.mem_ack   = (en_cyc == ack_after);
        bus.mem_rdata = (en_cyc == ack_after) ? rd : $urandom;
        en_cyc++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_ack = 1'b0;
    chk({tag, ".resp_seen"}, {31'b0, bus.resp_valid}, 32'd1);
    chk({tag, ".latency"}, 32'(cyc), mis ? 32'd0 : acked ? 32'(ack_after + 1) : 32'(TO));
    chk({tag, ".en_cycles"}, 32'(en_cyc), mis ? 32'd0 : acked ? 32'(ack_after + 1) : 32'(TO));
    chk({tag, ".align_fault"}, {31'b0, bus.align_fault}, {31'b0, mis});
    chk({tag, ".bus_fault"}, {31'b0, bus.bus_fault}, {31'b0, !mis && !acked});
    chk({tag, ".data"}, bus.data_from_mem, exp_d);
    model_dfm = exp_d;
    @(negedge clk);
    chk({tag, ".resp_drop"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'b0, bus.req_ready}, 32'd1);
    chk({tag, ".flags_clear"}, {30'b0, bus.align_fault, bus.bus_fault}, 32'd0);
  endtask

  initial begin
    logic [31:0] rds [3];
    int k;
    int last;
    int en_total;
    logic [1:0] rs;
    logic [31:0] ra;

    nvec = 0;
    nfail = 0;
    model_dfm = 32'h0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_size  = 2'b00;
    bus.req_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst.mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst.mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.mem_be", {28'b0, bus.mem_be}, 32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst.resp", {29'b0, bus.resp_valid, bus.align_fault, bus.bus_fault}, 32'h0);
    chk("rst.data", bus.data_from_mem, 32'h0);
    rst = 1'b0;

    // Reset during ACCESS abandons the access; a late ack is ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0040;
    bus.req_size  = 2'b11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstmid.en1", {31'b0, bus.mem_en}, 32'd1);
    @(negedge clk);
    chk("rstmid.en2", {31'b0, bus.mem_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.en_off", {31'b0, bus.mem_en}, 32'd0);
    chk("rstmid.no_resp", {31'b0, bus.resp_valid}, 32'd0);
    chk("rstmid.ready", {31'b0, bus.req_ready}, 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid.late_ack_resp", {31'b0, bus.resp_valid}, 32'd0);
      chk("rstmid.late_ack_en", {31'b0, bus.mem_en}, 32'd0);
      chk("rstmid.data", bus.data_from_mem, 32'h0);
    end
    bus.mem_ack = 1'b0;

    // Directed cases
    xfer("byte_ld", 1'b0, 32'h0000_1003, 2'b00, 32'h0, 32'hA1B2_C3D4, 1);
    chk("byte_ld.value", bus.data_from_mem, 32'h0000_00A1);
    xfer("half_st", 1'b1, 32'h0000_2002, 2'b01, 32'h0000_BEEF, 32'h0, 0);
    chk("half_st.data_kept", bus.data_from_mem, 32'h0000_00A1);
    xfer("word_ld_unal", 1'b0, 32'h0000_3001, 2'b11, 32'h0, 32'h1122_3344, 0);
`ifdef MAU_ROTATE_UNALIGNED_EN
    chk("word_ld_unal.value", bus.data_from_mem, 32'h4411_2233);
`else
    chk("word_ld_unal.value", bus.data_from_mem, 32'h0000_00A1);
`endif
    xfer("half_ld_unal", 1'b0, 32'h0000_3003, 2'b01, 32'h0, 32'h5566_7788, 0);
    xfer("size10_ld", 1'b0, 32'h0000_3008, 2'b10, 32'h0, 32'hCAFE_F00D, 2);
    xfer("timeout_ld", 1'b0, 32'h0000_4000, 2'b00, 32'h0, 32'h1234_5678, TO);
    xfer("timeout_st", 1'b1, 32'h0000_4001, 2'b00, 32'h0000_005A, 32'h0, TO);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = ra[1:0] & ((rs == 2'b00) ? 2'b11 : (rs == 2'b01) ? 2'b10 : 2'b00);
      xfer("rand", 1'($urandom_range(0, 1)), ra, rs, $urandom, $urandom, $urandom_range(0, TO));
    end

    // Back-to-back word loads with req_valid held high
    rds[0] = $urandom;
    rds[1] = $urandom;
    rds[2] = $urandom;
    k = 0;
    last = 0;
    en_total = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b11;
    bus.req_addr  = 32'h0000_0100;
    for (int cyc = 1; cyc < 40 && k < 3; cyc++) begin
      @(negedge clk);
      if (bus.mem_en) en_total++;
      bus.mem_ack   = bus.mem_en;
      bus.mem_rdata = rds[k];
      if (bus.resp_valid) begin
        chk("b2b.data", bus.data_from_mem, rds[k]);
        if (k > 0) chk("b2b.gap", 32'(cyc - last), 32'd3);
        last = cyc;
        k++;
        if (k == 3) bus.req_valid = 1'b0;
        else bus.req_addr = 32'h0000_0100 + 32'(4 * k);
      end
    end
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    chk("b2b.resp_count", 32'(k), 32'd3);
    chk("b2b.en_count", 32'(en_total), 32'd3);
    model_dfm = rds[2];
    @(negedge clk);
    chk("b2b.idle", {31'b0, bus.req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential bus-side stage between the CPU datapath/microsequencer and external memory.
- Takes an access request (address, size, read/write, store data) and runs a single-outstanding handshake with a variable-latency memory.
- Performs little-endian byte-lane steering for stores.
- For loads, right-justifies and zero-fills the selected lanes into data_from_mem, which feeds the load extension logic. Sign/zero extension is not done here.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in ACCESS waiting for mem_ack before a bus fault. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU requests an access
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 = byte, 01 = halfword, 11 = word; 10 is treated as word
- req_wdata  in  32  store data, right-justified
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid when mem_ack
- mem_ack  in  1  memory completes the access
- resp_valid  out  1  one-cycle completion pulse
- align_fault  out  1  with resp_valid: misaligned access, no memory cycle issued
- bus_fault  out  1  with resp_valid: timeout
- data_from_mem  out  32  extracted load data, zero-filled above size

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values:
  - State = IDLE.
  - All outputs 0, except req_ready = 1.
  - data_from_mem = 0.
  - Timeout counter = 0.
- Reset mid-operation: the next edge returns to IDLE and deasserts mem_en. The in-flight access is abandoned and no resp_valid is issued.
- req_ready = (state == IDLE).
- IDLE:
  - On accept, latch addr, size, we and wdata.
  - Misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
  - If misaligned → RESP with align_fault = 1. mem_en is never asserted.
  - Otherwise → ACCESS.
- ACCESS:
  - mem_en = 1; mem_we, mem_addr, mem_be and mem_wdata are held stable from latched values.
  - Counter increments each cycle.
  - If mem_ack → RESP, and capture data on loads.
  - Else if counter == TIMEOUT_CYCLES-1 → RESP with bus_fault = 1; data_from_mem is unchanged.
- RESP:
  - resp_valid = 1 for exactly one cycle, with fault flags valid alongside it.
  - → IDLE; counter and fault flags clear on exit.
- Minimum latency: accept at T, mem_en at T+1, ack at T+1, resp_valid at T+2. A new request can be accepted at T+3.
- mem_ack outside ACCESS is ignored.
- Store lane steering (little-endian):
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
- Loads: mem_be = 4'b1111.
- Load extraction, applied to mem_rdata when ack arrives:
  - Byte: {24'h0, rdata[8·a+7 : 8·a]}, where a = addr[1:0].
  - Half: {16'h0, addr[1] ? rdata[31:16] : rdata[15:0]}.
  - Word: rdata.
- data_from_mem holds its value until the next successful load. Stores and faults leave it unchanged.

Optional Feature:
- Macro: MAU_ROTATE_UNALIGNED_EN.
- When defined:
  - A word load with addr[1:0] != 0 is not misaligned. An aligned word access is issued and data_from_mem = rdata rotated right by 8·addr[1:0] (ARMv4 LDR semantics).
  - A word store with addr[1:0] != 0 is issued aligned with be = 4'b1111, with the address low bits ignored.
  - Halfword misalignment still raises align_fault.
- When undefined: all misalignment raises align_fault as described in Behaviour.

Decomposition:
- Shared package mau_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - Size constants SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11.
  - Counter width, derived as $clog2(TIMEOUT_CYCLES+1).
- One sub-module, mau_lane_steer: purely combinational. It covers be generation, store replication, load extraction and rotation.
- The FSM, latches and counter stay in mem_access_unit.

Test Plan:
- Byte load, addr 0x1003, mem_rdata 0xA1B2C3D4, ack one cycle after mem_en → resp_valid at T+3, data_from_mem = 0x000000A1, mem_be = 4'hF, mem_addr = 0x1000.
- Halfword store, addr 0x2002, wdata 0x0000BEEF → mem_be = 4'b1100, mem_wdata = 0xBEEFBEEF, mem_we = 1; data_from_mem unchanged.
- Word load, addr 0x3001, macro undefined → resp_valid at T+1 with align_fault = 1, mem_en never high. With macro defined and rdata 0x11223344 → data_from_mem = 0x44112233.
- No ack, TIMEOUT_CYCLES = 4 → mem_en high exactly 4 cycles, then resp_valid with bus_fault = 1; req_ready returns to 1 the next cycle.
- rst asserted during ACCESS → next cycle state IDLE, mem_en = 0, no resp_valid. A late mem_ack is ignored and data_from_mem stays 0.
- Back-to-back: hold req_valid for 3 word loads with immediate ack → each accepted only when req_ready is high, 3 resp_valid pulses, data matches each rdata.
